// File: rtl/wb_pkg.sv
// Shared widths, result-pair entry type and forwarding-packet helper
// for the dual-lane writeback stage.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int PKT_W  = 20;
  localparam logic [PKT_W-1:0] PKT_IDLE = 20'h80000;

  typedef struct packed {
    logic              valid1;
    logic [REG_AW-1:0] rd1;
    logic [DATA_W-1:0] val1;
    logic              valid2;
    logic [REG_AW-1:0] rd2;
    logic [DATA_W-1:0] val2;
  } wb_pair_t;

  // Bit 19 is an active-high invalid flag, so a dead lane maps to PKT_IDLE.
  function automatic logic [PKT_W-1:0] pack_pkt(input logic              valid,
                                                input logic [DATA_W-1:0] value,
                                                input logic [REG_AW-1:0] rd);
    return valid ? {1'b0, value, rd} : PKT_IDLE;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of result pairs with registered full/empty flags
// derived from an internal occupancy count.
import wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  wb_pair_t wdata,
  input  logic     pop,
  output wb_pair_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  wb_pair_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/writeback_unit.sv
// Dual-lane writeback: buffers result pairs, drains one pair per cycle into
// the register file and forwards both results to decode.
import wb_pkg::*;

module writeback_unit #(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int REG_AW     = wb_pkg::REG_AW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid1,
  input  logic [REG_AW-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_val1,
  input  logic              in_valid2,
  input  logic [REG_AW-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_val2,
  output logic              in_ready,
  input  logic              wb_hold,
  output logic              rf_we1,
  output logic [REG_AW-1:0] rf_waddr1,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic              rf_we2,
  output logic [REG_AW-1:0] rf_waddr2,
  output logic [DATA_W-1:0] rf_wdata2,
  output logic [19:0]       rdvalmem1,
  output logic [19:0]       rdvalmem2,
  output logic              stall_out,
  output logic [15:0]       retired_count
);

  // Handshake: a pair transfers on any edge where in_ready is high and at
  // least one lane valid is high; in_ready depends only on registered state.

  wb_pair_t enq_pair;
  wb_pair_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;
  logic     we1_next;

  assign enq_pair  = '{valid1: in_valid1, rd1: in_rd1, val1: in_val1,
                       valid2: in_valid2, rd2: in_rd2, val2: in_val2};
  assign in_ready  = !fifo_full;
  assign stall_out = fifo_full;
  assign push      = in_ready && (in_valid1 || in_valid2);
  assign pop       = !fifo_empty && !wb_hold;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (enq_pair),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Younger lane wins a same-register conflict on both write and forward paths.
  assign we1_next = head.valid1 && !(head.valid2 && (head.rd1 == head.rd2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we1        <= 1'b0;
      rf_waddr1     <= '0;
      rf_wdata1     <= '0;
      rf_we2        <= 1'b0;
      rf_waddr2     <= '0;
      rf_wdata2     <= '0;
      rdvalmem1     <= PKT_IDLE;
      rdvalmem2     <= PKT_IDLE;
      retired_count <= '0;
    end else if (pop) begin
      rf_we1        <= we1_next;
      rf_waddr1     <= head.rd1;
      rf_wdata1     <= head.val1;
      rf_we2        <= head.valid2;
      rf_waddr2     <= head.rd2;
      rf_wdata2     <= head.val2;
      rdvalmem1     <= pack_pkt(head.valid2, head.val2, head.rd2);
      rdvalmem2     <= pack_pkt(we1_next, head.val1, head.rd1);
      retired_count <= retired_count + 16'(head.valid1) + 16'(head.valid2);
    end else begin
      rf_we1    <= 1'b0;
      rf_we2    <= 1'b0;
      rdvalmem1 <= PKT_IDLE;
      rdvalmem2 <= PKT_IDLE;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with hand-computed expectations.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        in_valid1;
  logic [2:0]  in_rd1;
  logic [15:0] in_val1;
  logic        in_valid2;
  logic [2:0]  in_rd2;
  logic [15:0] in_val2;
  logic        in_ready;
  logic        wb_hold;
  logic        rf_we1;
  logic [2:0]  rf_waddr1;
  logic [15:0] rf_wdata1;
  logic        rf_we2;
  logic [2:0]  rf_waddr2;
  logic [15:0] rf_wdata2;
  logic [19:0] rdvalmem1;
  logic [19:0] rdvalmem2;
  logic        stall_out;
  logic [15:0] retired_count;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  writeback_unit #(
    .DATA_W     (16),
    .REG_AW     (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid1     (in_valid1),
    .in_rd1        (in_rd1),
    .in_val1       (in_val1),
    .in_valid2     (in_valid2),
    .in_rd2        (in_rd2),
    .in_val2       (in_val2),
    .in_ready      (in_ready),
    .wb_hold       (wb_hold),
    .rf_we1        (rf_we1),
    .rf_waddr1     (rf_waddr1),
    .rf_wdata1     (rf_wdata1),
    .rf_we2        (rf_we2),
    .rf_waddr2     (rf_waddr2),
    .rf_wdata2     (rf_wdata2),
    .rdvalmem1     (rdvalmem1),
    .rdvalmem2     (rdvalmem2),
    .stall_out     (stall_out),
    .retired_count (retired_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v1, input logic [2:0] rd1, input logic [15:0] val1,
                        input logic v2, input logic [2:0] rd2, input logic [15:0] val2);
    in_valid1 = v1;
    in_rd1    = rd1;
    in_val1   = val1;
    in_valid2 = v2;
    in_rd2    = rd2;
    in_val2   = val2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"}, 32'({rf_we1, rf_we2}), 32'h0);
    check({tag, "_pkt1"}, 32'(rdvalmem1), 32'h80000);
    check({tag, "_pkt2"}, 32'(rdvalmem2), 32'h80000);
  endtask

  initial begin
    reset   = 1'b1;
    wb_hold = 1'b0;
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    tick();
    tick();
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_stall", 32'(stall_out), 32'h0);
    check("rst_addr", 32'({rf_waddr1, rf_waddr2}), 32'h0);
    check("rst_data1", 32'(rf_wdata1), 32'h0);
    check("rst_data2", 32'(rf_wdata2), 32'h0);
    check("rst_count", 32'(retired_count), 32'h0);
    check_idle("rst");
    reset = 1'b0;
    tick();

    // Single lane 1
    set_in(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    check("single_early", 32'(rf_we1), 32'h0);
    tick();
    check("single_we1", 32'(rf_we1), 32'h1);
    check("single_we2", 32'(rf_we2), 32'h0);
    check("single_addr", 32'(rf_waddr1), 32'h3);
    check("single_data", 32'(rf_wdata1), 32'h1234);
    check("single_pkt2", 32'(rdvalmem2), 32'h091A3);
    check("single_pkt1", 32'(rdvalmem1), 32'h80000);
    check("single_cnt", 32'(retired_count), 32'd1);
    tick();
    check_idle("single_after");

    // Dual, distinct destinations
    set_in(1'b1, 3'd1, 16'd5, 1'b1, 3'd2, 16'd9);
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    tick();
    check("dual_we", 32'({rf_we1, rf_we2}), 32'h3);
    check("dual_addr", 32'({rf_waddr1, rf_waddr2}), 32'({3'd1, 3'd2}));
    check("dual_data", 32'({rf_wdata1, rf_wdata2}), 32'h0005_0009);
    check("dual_pkt1", 32'(rdvalmem1), 32'h0004A);
    check("dual_pkt2", 32'(rdvalmem2), 32'h00029);
    check("dual_cnt", 32'(retired_count), 32'd3);

    // Same destination: lane 2 wins
    set_in(1'b1, 3'd4, 16'd7, 1'b1, 3'd4, 16'd8);
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    tick();
    check("same_we", 32'({rf_we1, rf_we2}), 32'h1);
    check("same_addr2", 32'(rf_waddr2), 32'h4);
    check("same_data2", 32'(rf_wdata2), 32'd8);
    check("same_pkt1", 32'(rdvalmem1), 32'h00044);
    check("same_pkt2", 32'(rdvalmem2), 32'h80000);
    check("same_cnt", 32'(retired_count), 32'd5);
    tick();

    // Backpressure: fill under hold, 5th pair refused
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b1, 3'(i + 4), 16'h0200 + 16'(i));
      exp_q.push_back({16'h0100 + 16'(i), 16'h0200 + 16'(i)});
      tick();
      check("hold_we", 32'({rf_we1, rf_we2}), 32'h0);
    end
    check("full_stall", 32'(stall_out), 32'h1);
    check("full_ready", 32'(in_ready), 32'h0);
    set_in(1'b1, 3'd7, 16'hDEAD, 1'b1, 3'd6, 16'hBEEF);
    tick();
    check("full_hold_stall", 32'(stall_out), 32'h1);
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      tick();
      e = exp_q.pop_front();
      check("drain_we", 32'({rf_we1, rf_we2}), 32'h3);
      check("drain_data", {rf_wdata1, rf_wdata2}, e);
      check("drain_stall", 32'(stall_out), 32'h0);
    end
    tick();
    check_idle("drain_after");
    check("drain_cnt", 32'(retired_count), 32'd13);

    // Reset mid-stream while a drain is on the outputs
    set_in(1'b1, 3'd1, 16'h0AAA, 1'b1, 3'd2, 16'h0BBB);
    tick();
    tick();
    tick();
    check("pre_rst_we", 32'({rf_we1, rf_we2}), 32'h3);
    reset = 1'b1;
    #1;
    check_idle("mid_rst");
    check("mid_rst_cnt", 32'(retired_count), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h1);
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_we", 32'({rf_we1, rf_we2}), 32'h0);
    end
    check("post_rst_cnt", 32'(retired_count), 32'h0);

    // Counter wrap: 32768 dual-lane drains
    set_in(1'b1, 3'd5, 16'h0055, 1'b1, 3'd6, 16'h0066);
    for (int i = 0; i < 32768; i++) tick();
    check("wrap_pre", 32'(retired_count), 32'hFFFE);
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    tick();
    check("wrap_we", 32'({rf_we1, rf_we2}), 32'h3);
    check("wrap_cnt", 32'(retired_count), 32'h0);
    tick();
    check_idle("wrap_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Dual-lane writeback stage of the superscalar pipeline. It accepts up to two results per cycle from the execute/memory lanes and buffers them in a small FIFO. It drains one result pair per cycle into the two register-file write ports. In the same cycle it broadcasts the 20-bit forwarding packets `rdvalmem1`/`rdvalmem2` consumed by the decode stage, and it raises `stall_out` back to decode when its buffer is full.

## Interface
- `DATA_W`, 16, result/register data width
- `REG_AW`, 3, register address width (8 architectural registers)
- `FIFO_DEPTH`, 4, result-pair buffer depth (power of two, ≥2)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `in_valid1`  in  1  lane-1 (older instruction) result valid
- `in_rd1`  in  REG_AW  lane-1 destination register
- `in_val1`  in  DATA_W  lane-1 result
- `in_valid2`  in  1  lane-2 (younger instruction) result valid
- `in_rd2`  in  REG_AW  lane-2 destination register
- `in_val2`  in  DATA_W  lane-2 result
- `in_ready`  out  1  FIFO not full; a pair is accepted when `in_ready` is high and either valid is high
- `wb_hold`  in  1  register file busy; the FIFO head is not drained while high
- `rf_we1`, `rf_waddr1`, `rf_wdata1`  out  1/REG_AW/DATA_W  write port 1 (lane 1)
- `rf_we2`, `rf_waddr2`, `rf_wdata2`  out  1/REG_AW/DATA_W  write port 2 (lane 2)
- `rdvalmem1`  out  20  forwarding packet, younger (lane-2) result
- `rdvalmem2`  out  20  forwarding packet, older (lane-1) result
- `stall_out`  out  1  equal to `!in_ready`; drives the decode stall
- `retired_count`  out  16  count of retired instructions

## Operation
- Packet format: bit 19 = invalid flag (0 = valid), bits [18:3] = value, bits [2:0] = rd. The idle packet is 20'h80000.
- Enqueue:
  - When `in_ready` and (`in_valid1` | `in_valid2`), write {valid1, rd1, val1, valid2, rd2, val2} at the tail.
  - A pair with both valids low is not stored.
- Drain:
  - When not empty and `!wb_hold`, pop the head and register its outputs:
    - `rf_we1` = valid1 & !(valid2 & rd1 == rd2).
    - `rf_we2` = valid2.
    - Addresses and data are taken from the entry.
  - Otherwise all `rf_we*` are 0 and both packets are idle.
- Forwarding priority: decode checks `rdvalmem1` first.
  - `rdvalmem1` = lane-2 packet if valid2, else idle.
  - `rdvalmem2` = lane-1 packet if valid1 and not same-rd-suppressed, else idle.
- Same-rd conflict: the younger result (lane 2) wins on both the write and the forwarding path.
- `retired_count`:
  - Increments by valid1 + valid2 of the drained entry (0, 1 or 2).
  - A suppressed lane-1 write still counts.
  - Wraps modulo 2^16.
- Full: `in_ready` = 0. This is based on the registered count, so there is no enqueue even if a dequeue happens in the same cycle.
- Simultaneous enqueue and dequeue when not full: occupancy is unchanged and pointers advance independently; pointers wrap at `FIFO_DEPTH`.

## Timing
- Reset values:
  - FIFO empty, pointers 0.
  - `in_ready` = 1, `stall_out` = 0.
  - `rf_we*` = 0, `rf_waddr*` = 0, `rf_wdata*` = 0.
  - `rdvalmem1`/`rdvalmem2` = 20'h80000.
  - `retired_count` = 0.
- Reset mid-operation discards all buffered results with no writes emitted.
- Latency: a pair accepted at edge k, with the FIFO empty and `wb_hold` low, appears on the outputs after edge k+1. Throughput is one pair per cycle.
- Outputs are valid for exactly one cycle per drained entry and are idle otherwise.
- `wb_hold` is sampled at the drain edge. While it is high the head is retained, the outputs are idle, and the FIFO can fill.
- `in_ready`/`stall_out` are registered functions of occupancy: deasserted the cycle after occupancy reaches `FIFO_DEPTH`, reasserted the cycle after a pop from full.

## Structure
- Package `wb_pkg`:
  - `DATA_W`, `REG_AW`, `PKT_W` = 20, `PKT_IDLE` = 20'h80000.
  - Result-pair struct type.
  - Pack function (valid, value, rd) -> packet.
- Sub-module `wb_fifo`: synchronous FIFO of result-pair entries with registered full/empty and an occupancy count. Conflict resolution, output registers and the counter stay in the top module.

## Test plan
- Single lane: after reset, lane 1 {rd=3, val=16'h1234}, lane 2 invalid -> next cycle `rf_we1`=1, addr 3, data 1234; `rdvalmem2`=20'h0_91A3 (bit 19=0, value=1234, rd=3); `rdvalmem1`=20'h80000; `retired_count`=1.
- Dual, distinct rd: lane 1 {rd=1, val=5}, lane 2 {rd=2, val=9} -> both writes in the same cycle; `rdvalmem1` carries rd 2/value 9; count +2.
- Same rd: both lanes rd=4, values 7 and 8 -> `rf_we1`=0, `rf_we2`=1 with data 8; `rdvalmem1` carries value 8; `rdvalmem2` idle; count +2.
- Backpressure: hold `wb_hold`=1 and push 5 pairs -> 4 accepted, then `stall_out`=1 and the 5th pair is held. Release `wb_hold` -> 4 pairs drain in order, one per cycle, and `stall_out` drops the cycle after the first pop.
- Reset mid-stream: fill 3 entries, assert `reset` -> outputs idle immediately; no writes after deassert; `retired_count`=0.
- Counter wrap: preload via 32768 dual-lane drains -> `retired_count` returns to 0.
